// File: rtl/uart_rx_fifo_if.sv
// Consumer-side ready/valid bundle of the UART receiver: FIFO head data,
// per-entry error flags and the sticky overrun flag.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_data_valid;
    logic                 rx_data_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;

    modport master (
        output rx_data, rx_data_valid, rx_parity_err, rx_frame_err, rx_overrun,
        input  rx_data_ready
    );

    modport slave (
        input  rx_data, rx_data_valid, rx_parity_err, rx_frame_err, rx_overrun,
        output rx_data_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (5-9 data bits, none/odd/even parity, 1-2 stop bits) feeding a small
// receive FIFO. Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module uart_rx_fifo #(
    parameter int CLK_FRE    = 50,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_pin,
    uart_rx_fifo_if.master  rx_if
);
    localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC = CYCLE / 2;
`else
    localparam int DEC = CYCLE / 2 - 1;
`endif
    localparam logic [15:0] DEC_PT = 16'(DEC);
    localparam logic [15:0] END_PT = 16'(CYCLE - 1);
    localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic        ODD = (PARITY == 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic                 prev_q;
    logic [1:0]           warm_q;
    logic                 line_ok_q;
    logic                 fall;
    logic                 bit_val;
    logic [15:0]          cnt;
    logic [3:0]           bit_cnt;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 frm_err;
    logic                 at_dec, at_end, last_bit, last_stop;
    logic                 cnt_clr, push;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [EW-1:0]        head;
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 empty, full, pop, push_ok;
    logic                 overrun;

    // Two-flop synchroniser plus edge history. Edges are only honoured once the
    // synchronised line has been seen high after reset, so a line held low
    // through reset release cannot start a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            warm_q    <= 2'b00;
            line_ok_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx_pin};
            prev_q    <= sync_q[1];
            warm_q    <= {warm_q[0], 1'b1};
            line_ok_q <= line_ok_q | (warm_q[1] & sync_q[1]);
        end
    end

    assign fall = prev_q & ~sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    localparam logic [15:0] MAJ0_PT = 16'(CYCLE / 2 - 2);
    localparam logic [15:0] MAJ1_PT = 16'(CYCLE / 2 - 1);
    logic [1:0] maj_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj_q <= 2'b11;
        end else begin
            if (cnt == MAJ0_PT) maj_q[1] <= sync_q[1];
            if (cnt == MAJ1_PT) maj_q[0] <= sync_q[1];
        end
    end

    assign bit_val = (maj_q[1] & maj_q[0]) | (maj_q[1] & sync_q[1]) | (maj_q[0] & sync_q[1]);
`else
    assign bit_val = sync_q[1];
`endif

    assign at_dec    = (cnt == DEC_PT);
    assign at_end    = (cnt == END_PT);
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // The final stop bit ends at its decision point so a following start edge
    // arriving a half bit later is not missed.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (fall && line_ok_q) state_d = START;
            end
            START: begin
                if (at_dec && bit_val) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (at_end) begin
                    state_d = DATA;
                    cnt_clr = 1'b1;
                end
            end
            DATA: begin
                if (at_end) begin
                    cnt_clr = 1'b1;
                    if (last_bit) state_d = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                if (at_end) begin
                    cnt_clr = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_dec && last_stop) begin
                    push    = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (at_end) begin
                    cnt_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            cnt <= cnt_clr ? 16'd0 : cnt + 16'd1;
            if (state_q == IDLE) begin
                bit_cnt  <= '0;
                stop_idx <= 1'b0;
                par_err  <= 1'b0;
                frm_err  <= 1'b0;
            end
            if (state_q == DATA && at_dec) shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            if (state_q == DATA && at_end) bit_cnt <= bit_cnt + 4'd1;
            if (state_q == PAR && at_dec)  par_err <= ((^shreg) ^ bit_val) != ODD;
            if (state_q == STOP && at_dec && !bit_val) frm_err <= 1'b1;
            if (state_q == STOP && at_end) stop_idx <= 1'b1;
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && rx_if.rx_data_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= {frm_err | ~bit_val, par_err, shreg};
    end

    // A push against a full FIFO only drops the frame when no pop frees a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop) overrun <= 1'b1;
            else if (pop)             overrun <= 1'b0;
        end
    end

    assign head                = mem[rd_ptr[AW-1:0]];
    assign rx_if.rx_data_valid = !empty;
    assign rx_if.rx_data       = empty ? '0 : head[DATA_BITS-1:0];
    assign rx_if.rx_parity_err = empty ? 1'b0 : head[DATA_BITS];
    assign rx_if.rx_frame_err  = empty ? 1'b0 : head[DATA_BITS+1];
    assign rx_if.rx_overrun    = overrun;
endmodule
